// File: rtl/led_serial_driver_pkg.sv
// Shared types and constants for the serial LED shift-register driver.
package led_serial_driver_pkg;
  localparam int LED_FRAME_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;
endpackage

// File: rtl/led_sclk_tick.sv
// Half-period phase counter: tick marks the last cycle of each CLK_DIV-cycle phase.
module led_sclk_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam logic [7:0] TC = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr || tick) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_serial_driver.sv
// Serialises a 16-bit LED pattern MSB-first into an external shift-register chain,
// resending only on change, on refresh, or once after reset.
module led_serial_driver
  import led_serial_driver_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LED_FRAME_WIDTH-1:0] led_state,
  input  logic                       refresh,
  output logic                       sclk,
  output logic                       sdata,
  output logic                       latch,
  output logic                       busy
);
  state_e                     state_q, state_d;
  logic [3:0]                 bit_q, bit_d;
  logic                       half_q, half_d;
  logic [LED_FRAME_WIDTH-1:0] shadow_q, shadow_d;
  logic [LED_FRAME_WIDTH-1:0] last_q, last_d;
  logic                       valid_q, valid_d;
  logic                       sclk_q, sclk_d, sdata_q, sdata_d;
  logic                       latch_q, latch_d, busy_q, busy_d;
  logic                       tick;

  led_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    half_d   = half_q;
    shadow_d = shadow_q;
    last_d   = last_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (refresh || (led_state != last_q) || !valid_q) begin
          shadow_d = led_state;
          state_d  = SHIFT;
          bit_d    = 4'hF;
          half_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_q == 4'd0) state_d = LATCH;
            else               bit_d   = bit_q - 4'd1;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_d = IDLE;
          last_d  = shadow_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    sclk_d  = (state_d == SHIFT) && half_d;
    sdata_d = (state_d == SHIFT) && shadow_d[bit_d];
    latch_d = (state_d == LATCH);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bit_q    <= 4'd0;
      half_q   <= 1'b0;
      shadow_q <= '0;
      last_q   <= '0;
      valid_q  <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      half_q   <= half_d;
      shadow_q <= shadow_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      latch_q  <= latch_d;
      busy_q   <= busy_d;
    end
  end

  assign sclk  = sclk_q;
  assign sdata = sdata_q;
  assign latch = latch_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_led_serial_driver.sv
// Directed bench: expected frames queued at stimulus time, popped as frames latch.
module tb_led_serial_driver;
  localparam int CD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] led, led1;
  logic        refresh, refresh1;
  logic        sclk, sdata, latch, busy;
  logic        sclk1, sdata1, latch1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_serial_driver #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .led_state(led), .refresh(refresh),
    .sclk(sclk), .sdata(sdata), .latch(latch), .busy(busy)
  );

  led_serial_driver #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .led_state(led1), .refresh(refresh1),
    .sclk(sclk1), .sdata(sdata1), .latch(latch1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_q[$];

  // Monitor for the CLK_DIV=2 instance
  int          bits, rises_total, latch_len, busy_len, idle_len, last_gap;
  int          frames_done, latch_pulses;
  logic [15:0] word;
  logic        p_sclk, p_latch, p_busy;

  initial begin
    bits = 0; rises_total = 0; latch_len = 0; busy_len = 0; idle_len = 0;
    last_gap = -1; frames_done = 0; latch_pulses = 0; word = '0;
    p_sclk = 0; p_latch = 0; p_busy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bits = 0; word = '0; latch_len = 0; busy_len = 0; idle_len = 0;
        p_sclk = 0; p_latch = 0; p_busy = 0;
      end else begin
        if (sclk && !p_sclk) begin
          word = {word[14:0], sdata};
          bits++;
          rises_total++;
        end
        if (latch) latch_len++;
        if (busy) busy_len++; else idle_len++;
        if (busy && !p_busy) begin
          last_gap = idle_len;
          idle_len = 0;
        end
        if (!latch && p_latch) begin
          latch_pulses++;
          chk("latch_len", latch_len, CD);
          chk("bit_count", bits, 16);
          if (exp_q.size() == 0) chk("unexpected_frame", word, 32'hDEAD);
          else                   chk("frame_word", word, exp_q.pop_front());
        end
        if (!busy && p_busy) begin
          chk("busy_len", busy_len, 33 * CD);
          chk("idle_outputs", {sclk, sdata, latch}, 3'b000);
          frames_done++;
          bits = 0; word = '0; latch_len = 0; busy_len = 0;
        end
        p_sclk = sclk; p_latch = latch; p_busy = busy;
      end
    end
  end

  // Monitor for the CLK_DIV=1 instance
  int          b1_len, hi1, last_b1, last_hi1, frames1;
  logic [15:0] w1, last_w1;
  logic        tog_ok, last_tog, p_sclk1, p_busy1;

  initial begin
    b1_len = 0; hi1 = 0; last_b1 = 0; last_hi1 = 0; frames1 = 0;
    w1 = '0; last_w1 = '0; tog_ok = 1; last_tog = 0; p_sclk1 = 0; p_busy1 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b1_len = 0; hi1 = 0; w1 = '0; tog_ok = 1; p_sclk1 = 0; p_busy1 = 0;
      end else begin
        if (busy1 && !latch1 && b1_len > 0 && sclk1 == p_sclk1) tog_ok = 0;
        if (busy1) b1_len++;
        if (sclk1) begin
          hi1++;
          if (!p_sclk1) w1 = {w1[14:0], sdata1};
        end
        if (!busy1 && p_busy1) begin
          last_b1 = b1_len; last_hi1 = hi1; last_w1 = w1; last_tog = tog_ok;
          frames1++;
          b1_len = 0; hi1 = 0; w1 = '0; tog_ok = 1;
        end
        p_sclk1 = sclk1; p_busy1 = busy1;
      end
    end
  end

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, frames_done, target);
  endtask

  task automatic wait_bits(input string tag, input int target, input int budget);
    int n = 0;
    while (bits < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, bits, target);
  endtask

  initial begin
    int snap_rises, snap_frames, snap_latch;
    rst_n = 1'b0; led = 16'h0000; refresh = 1'b0;
    led1 = 16'hA5C3; refresh1 = 1'b0;

    // Reset state, then the unconditional first frame of an all-zero pattern
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {sclk, sdata, latch, busy}, 4'b0000);
    exp_q.push_back(16'h0000);
    rst_n = 1'b1;
    wait_frames("first_frame", 1, 300);

    // Pattern change in IDLE
    @(posedge clk); #1;
    exp_q.push_back(16'h8001);
    led = 16'h8001;
    wait_frames("frame_8001", 2, 300);

    // Constant pattern: nothing resent until refresh, then exactly one frame
    @(posedge clk); #1;
    exp_q.push_back(16'hFFFF);
    led = 16'hFFFF;
    wait_frames("frame_ffff", 3, 300);
    snap_rises = rises_total;
    repeat (200) @(posedge clk);
    chk("quiet_sclk", rises_total, snap_rises);
    chk("quiet_frames", frames_done, 3);
    #1 exp_q.push_back(16'hFFFF);
    refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
    wait_frames("refresh_frame", 4, 300);
    repeat (100) @(posedge clk);
    chk("refresh_once", frames_done, 4);

    // Pattern change mid-frame is deferred to the next frame
    #1 exp_q.push_back(16'h00FF);
    led = 16'h00FF;
    wait_bits("reach_bit5", 10, 300);
    @(posedge clk); #1;
    exp_q.push_back(16'hFF00);
    led = 16'hFF00;
    refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
    wait_frames("deferred_frames", 6, 600);
    chk("idle_gap", last_gap, 1);
    repeat (100) @(posedge clk);
    chk("no_extra_frame", frames_done, 6);

    // Asynchronous reset during bit 8 aborts without a latch pulse
    #1 exp_q.push_back(16'h1234);
    led = 16'h1234;
    wait_bits("reach_bit8", 7, 300);
    @(posedge clk); @(posedge clk);
    snap_latch = latch_pulses;
    snap_frames = frames_done;
    #3 rst_n = 1'b0;
    #1 chk("abort_outputs", {sclk, sdata, latch, busy}, 4'b0000);
    void'(exp_q.pop_front());
    repeat (3) @(posedge clk);
    chk("abort_no_latch", latch_pulses, snap_latch);
    #1 exp_q.push_back(16'h1234);
    rst_n = 1'b1;
    wait_frames("post_reset_frame", snap_frames + 1, 300);
    chk("queue_empty", exp_q.size(), 0);

    // CLK_DIV=1 instance
    repeat (10) @(posedge clk);
    chk("div1_frames", frames1 > 0, 1'b1);
    chk("div1_busy", last_b1, 33);
    chk("div1_sclk_hi", last_hi1, 16);
    chk("div1_word", last_w1, 16'hA5C3);
    chk("div1_toggle", last_tog, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_serial_driver.md
LED_SERIAL_DRIVER -- requirements
Module: led_serial_driver

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning clk cycles per sclk half-period; legal range 1..255.
REQ-002 Port clk  input  1  meaning single system clock; all logic on rising edge.
REQ-003 Port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-004 Port led_state  input  16  meaning LED pattern from the flasher core.
REQ-005 Port refresh  input  1  meaning single-cycle request to resend the current pattern even if unchanged.
REQ-006 Port sclk  output  1  meaning serial shift clock to an external 16-bit shift-register chain.
REQ-007 Port sdata  output  1  meaning serial data, MSB (led_state[15]) first, stable across each sclk rising edge.
REQ-008 Port latch  output  1  meaning storage-register strobe, active high.
REQ-009 Port busy  output  1  meaning frame in progress; high from first SHIFT cycle through last LATCH cycle.
REQ-010 All outputs SHALL be driven directly from flops; no combinational input-to-output paths.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and LATCH only.
REQ-012 In IDLE, a frame trigger SHALL be (refresh==1) OR (led_state != last_sent) OR (sent_valid==0).
REQ-013 On a trigger cycle, the block SHALL capture led_state into a 16-bit shadow register and enter SHIFT on the next cycle.
REQ-014 In SHIFT, each bit SHALL occupy 2*CLK_DIV cycles: CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1; sdata SHALL change only at the start of a low phase.
REQ-015 Bits SHALL be sent shadow[15] down to shadow[0]; a 4-bit bit index SHALL move to LATCH after the high phase of bit 0.
REQ-016 In LATCH, latch=1, sclk=0 and sdata=0 SHALL hold for CLK_DIV cycles; the block SHALL then return to IDLE, set last_sent=shadow and set sent_valid=1.
REQ-017 busy SHALL be high for exactly 33*CLK_DIV consecutive cycles per frame.
REQ-018 Changes to led_state and refresh pulses during SHIFT or LATCH SHALL be ignored and SHALL not alter the frame in flight; a pending difference SHALL trigger a new frame from IDLE via REQ-012.
REQ-019 IDLE SHALL last at least one cycle between frames; back-to-back triggers SHALL produce frames separated by exactly one idle cycle.
REQ-020 In IDLE, outputs SHALL be sclk=0, sdata=0, latch=0, busy=0.
REQ-021 Phase and bit counters SHALL wrap to 0 at their terminal counts and never overflow; CLK_DIV=1 SHALL give a 1-cycle half-period.

Reset
REQ-022 While rst_n=0: state=IDLE, sclk=0, sdata=0, latch=0, busy=0, shadow=0, last_sent=0, sent_valid=0, counters=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately with no latch pulse.
REQ-024 The first IDLE cycle after reset release SHALL trigger one frame (sent_valid=0), even when led_state=0.

Structure
REQ-025 The shared package SHALL hold the state enum (IDLE, SHIFT, LATCH) and constant LED_FRAME_WIDTH=16.
REQ-026 One sub-module, led_sclk_tick, SHALL implement the CLK_DIV phase counter with a clear input and a terminal-count pulse output.

Verification
REQ-027 Reset release, led_state=16'h0000, CLK_DIV=2 -> one frame; busy high for 66 cycles; 16 zeros shifted; one latch pulse of 2 cycles.
REQ-028 led_state changes 16'h0000->16'h8001 in IDLE -> captured bits on sclk rising edges are 1,0x14,1; then a 2-cycle latch pulse.
REQ-029 led_state 16'hFFFF held constant after its frame, no refresh -> no further sclk edges for 200 cycles; refresh pulse -> exactly one identical frame.
REQ-030 led_state changes 16'h00FF->16'hFF00 during bit 5 of a 16'h00FF frame -> frame completes as 16'h00FF; one idle cycle; next frame carries 16'hFF00.
REQ-031 rst_n pulsed low during bit 8 -> all outputs 0 asynchronously; no latch; full frame after release.
REQ-032 CLK_DIV=1, any pattern -> busy lasts 33 cycles; sclk toggles every cycle in SHIFT.
